bidir_bus_master: RTL
=====================

# bidir_bus_master

- Core-side sequencer for a half-duplex, 8-bit, strobed parallel bus whose pins are built from tri-state IO buffers.
- Converts single-word read/write requests into timed bus cycles: drives the buffer's data input and active-high tristate control, and samples the buffer's output.
- Enforces setup, strobe, hold and direction turnaround timing.
- Sits between a PicoBlaze port decoder and the pad ring, for example an LCD or external-register interface.

## Interface
- `SETUP_CYC`, default 2: cycles of address/data setup before the strobe; range 1–255.
- `STROBE_CYC`, default 4: cycles the strobe is high; range 1–255.
- `HOLD_CYC`, default 1: cycles after the strobe falls; range 1–255.
- `TURN_CYC`, default 2: cycles of bus release on a direction change; range 1–255.
- `clk` in 1: the only clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: request. Sampled only while `busy`=0.
- `we` in 1: 1 = write, 0 = read. Captured with `req`.
- `wdata` in 8: write data. Captured with `req`.
- `busy` out 1: a transaction is in progress.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 8: read data. Valid from `ack` until the next read completes.
- `bus_o` out 8: data to the buffer input `I`.
- `bus_t` out 1: buffer tristate control. 1 = released (high-Z), 0 = driving.
- `bus_i` in 8: data from the buffer output `O`.
- `bus_rw` out 1: bus direction pin. 1 = read, 0 = write.
- `bus_stb` out 1: bus strobe. Active high.

## Operation
- Reset values: `busy`=0, `ack`=0, `rdata`=0x00, `bus_o`=0x00, `bus_t`=1, `bus_rw`=1, `bus_stb`=0. The internal last-direction flag resets to read.
- FSM states: IDLE, TURN, SETUP, STROBE, HOLD. There is one 8-bit down-counter, loaded on every state entry.
- IDLE:
  - On `req`=1, latch `we` and `wdata`.
  - If `we` differs from the last-direction flag, go to TURN; otherwise go to SETUP.
  - `bus_t`, `bus_rw` and `bus_o` hold their previous values, so the bus stays parked after a write.
- TURN (`TURN_CYC` cycles):
  - `bus_t`=1, `bus_stb`=0, and `bus_rw` already reflects the new direction.
  - Update the last-direction flag, then go to SETUP.
- SETUP (`SETUP_CYC` cycles):
  - `bus_rw`=!we, `bus_t`=!we.
  - On a write, `bus_o`=wdata. On a read, `bus_o` holds its previous value.
- STROBE (`STROBE_CYC` cycles): `bus_stb`=1. On the last STROBE cycle of a read, capture `rdata` from the sample source (see Configuration).
- HOLD (`HOLD_CYC` cycles): `bus_stb`=0 and the direction is unchanged. Then return to IDLE with `ack`=1 for that one cycle.
- `busy` is 1 in every state except IDLE. A `req` presented while `busy`=1 is ignored, not queued.
- A request may be accepted in the same cycle `ack` is high, giving back-to-back transactions.
- `bus_t`=0 and `bus_rw`=1 never occur in the same cycle. The block never drives the bus during a read.

## Timing
- Request accepted at cycle 0. The first TURN or SETUP cycle is cycle 1.
- `ack` is high at cycle 1 + [TURN_CYC] + SETUP_CYC + STROBE_CYC + HOLD_CYC. TURN_CYC is included only on a direction change.
- With defaults and no turnaround, `ack` is at cycle 8. With turnaround it is at cycle 10.
- `rdata` updates on the clock edge ending the last STROBE cycle. It is stable for HOLD_CYC cycles before `ack`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-transaction: all outputs go to their reset values immediately, with no clock required. The bus is released and no `ack` is issued. The pending request is discarded.

## Configuration
- `BIDIR_BUS_SYNC_EN` defined:
  - `bus_i` passes through a two-flop synchronizer, and reads capture from the second flop.
  - The captured value is the pin value from two cycles before the last STROBE cycle.
  - Requires STROBE_CYC ≥ 3 for the peripheral's data to be fully captured inside the strobe.
- `BIDIR_BUS_SYNC_EN` not defined:
  - Reads capture `bus_i` directly on the last STROBE cycle. There are no extra flops.

## Test plan
All scenarios use default parameters.

- **Write after reset:** `req`=1, `we`=1, `wdata`=0xA5 at cycle 0.
  - Cycles 1–2: TURN, `bus_t`=1.
  - Cycles 3–9: `bus_t`=0, `bus_o`=0xA5, `bus_rw`=0.
  - `bus_stb`=1 in cycles 5–8.
  - `ack` at cycle 10.
- **Back-to-back writes:** a second write of 0x3C is issued in the `ack` cycle.
  - No TURN.
  - `bus_o`=0x3C from the following cycle.
  - `ack` 8 cycles after acceptance.
- **Read after write:** the peripheral drives 0x5A while `bus_t`=1.
  - Two TURN cycles with `bus_t`=1 and `bus_rw`=1.
  - `bus_t` never returns to 0.
  - `rdata`=0x5A at `ack`, 10 cycles after acceptance. Exercise both macro settings with `bus_i` stable throughout STROBE.
- **Request while busy:** pulse `req` with a write of 0xFF during STROBE.
  - Ignored: exactly one `ack`, and `bus_o` never equals 0xFF.
- **Reset mid-strobe:** assert `reset` in the 2nd STROBE cycle of a write.
  - Outputs are at reset values in the same cycle, with `bus_t`=1 and `bus_stb`=0.
  - No `ack` follows.
  - The next write takes the TURN path.
- **Minimum parameters:** all four parameters = 1, read.
  - TURN, SETUP, STROBE and HOLD last 1 cycle each.
  - `ack` at cycle 5.

Source files
------------

// File: rtl/bidir_bus_master.sv
// bidir_bus_master: core-side sequencer for a half-duplex 8-bit strobed bus
// built from tri-state IO buffers (setup / strobe / hold / turnaround).
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   req, we, wdata      single-word request (sampled only while idle)
//   busy, ack, rdata    status, one-cycle completion pulse, read data
//   bus_o, bus_t, bus_i buffer I, tristate control (1 = high-Z), buffer O
//   bus_rw, bus_stb     direction pin (1 = read), strobe (active high)
//
// Optional macro BIDIR_BUS_SYNC_EN: when defined, bus_i passes through a
// two-flop synchronizer and reads capture from the second flop.
module bidir_bus_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rdata,
    output logic [7:0] bus_o,
    output logic       bus_t,
    input  logic [7:0] bus_i,
    output logic       bus_rw,
    output logic       bus_stb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    state_t     state;
    state_t     next;
    logic [7:0] cnt;
    logic [7:0] cnt_ld;
    logic       cnt_done;
    logic       accept;

    // Latched request and the direction of the last completed turnaround
    // (1 = write, 0 = read).
    logic       we_q;
    logic [7:0] wdata_q;
    logic       last_we;

    // Effective request fields: the live inputs in the accept cycle,
    // the latched copies afterwards.
    logic       cur_we;
    logic [7:0] cur_wdata;

    logic       busy_d;
    logic       ack_d;
    logic [7:0] bus_o_d;
    logic       bus_t_d;
    logic       bus_rw_d;
    logic       bus_stb_d;
    logic       rd_cap;
    logic [7:0] sample;

    assign cnt_done  = (cnt == 8'd0);
    assign accept    = (state == S_IDLE) && req;
    assign cur_we    = accept ? we : we_q;
    assign cur_wdata = accept ? wdata : wdata_q;

`ifdef BIDIR_BUS_SYNC_EN
    logic [7:0] sync1;
    logic [7:0] sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= bus_i;
            sync2 <= sync1;
        end
    end

    assign sample = sync2;
`else
    assign sample = bus_i;
`endif

    // State register, down-counter and request latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            last_we <= 1'b0;
        end else begin
            state <= next;
            if (next != state) begin
                cnt <= cnt_ld;
            end else if (!cnt_done) begin
                cnt <= cnt - 8'd1;
            end
            if (accept) begin
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (state == S_TURN && cnt_done) begin
                last_we <= we_q;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    next = (we != last_we) ? S_TURN : S_SETUP;
                end
            end
            S_TURN:   if (cnt_done) next = S_SETUP;
            S_SETUP:  if (cnt_done) next = S_STROBE;
            S_STROBE: if (cnt_done) next = S_HOLD;
            S_HOLD:   if (cnt_done) next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    // Counter load value for the state being entered
    always_comb begin
        cnt_ld = 8'd0;
        unique case (next)
            S_TURN:   cnt_ld = TURN_LD;
            S_SETUP:  cnt_ld = SETUP_LD;
            S_STROBE: cnt_ld = STROBE_LD;
            S_HOLD:   cnt_ld = HOLD_LD;
            default:  cnt_ld = 8'd0;
        endcase
    end

    // Output logic: values for the coming cycle, registered below so
    // every output is a flop. Idle keeps the bus parked as it was left.
    always_comb begin
        busy_d    = (next != S_IDLE);
        ack_d     = (state == S_HOLD) && cnt_done;
        bus_stb_d = (next == S_STROBE);
        bus_o_d   = bus_o;
        bus_t_d   = bus_t;
        bus_rw_d  = bus_rw;
        rd_cap    = (state == S_STROBE) && cnt_done && !we_q;
        unique case (next)
            S_TURN: begin
                bus_t_d  = 1'b1;
                bus_rw_d = !cur_we;
            end
            S_SETUP, S_STROBE, S_HOLD: begin
                bus_t_d  = !cur_we;
                bus_rw_d = !cur_we;
                if (cur_we) begin
                    bus_o_d = cur_wdata;
                end
            end
            default: begin
                bus_t_d = bus_t;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            ack     <= 1'b0;
            rdata   <= 8'h00;
            bus_o   <= 8'h00;
            bus_t   <= 1'b1;
            bus_rw  <= 1'b1;
            bus_stb <= 1'b0;
        end else begin
            busy    <= busy_d;
            ack     <= ack_d;
            bus_o   <= bus_o_d;
            bus_t   <= bus_t_d;
            bus_rw  <= bus_rw_d;
            bus_stb <= bus_stb_d;
            if (rd_cap) begin
                rdata <= sample;
            end
        end
    end

endmodule
